// File: rtl/nregister_e_pkg.sv
// Shared defaults for the enabled register.
package nregister_e_pkg;

  // Default data width of io_D / io_Q.
  localparam int unsigned DefaultWidth = 8;

  // Default reset load value; sized to the widest legal register.
  localparam logic [63:0] DefaultResetValue = 64'h0;

endpackage : nregister_e_pkg

// File: rtl/nregister_e_bit.sv
// One bit of the enabled register: synchronous reset beats load enable.
module nregister_e_bit (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic en,
  input  logic rst_val,
  output logic q
);

  logic q_d;
  logic q_q;

  // Next state: reset value first, then load on enable, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (reset) begin
      q_d = rst_val;
    end else if (en) begin
      q_d = d;
    end
  end

  // State register; reset is folded into q_d so it is sampled on the edge.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule : nregister_e_bit

// File: rtl/nregister_e.sv
// WIDTH-bit register with load enable and synchronous active-high reset.
module nregister_e
  import nregister_e_pkg::*;
#(
  parameter int unsigned         WIDTH       = DefaultWidth,
  parameter logic [WIDTH-1:0]    RESET_VALUE = WIDTH'(DefaultResetValue)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_D,
  input  logic             io_enable,
  output logic [WIDTH-1:0] io_Q
);

  // One flop per bit; all share enable and reset so the word loads atomically.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nregister_e_bit u_bit (
      .clk     (clk),
      .reset   (reset),
      .d       (io_D[i]),
      .en      (io_enable),
      .rst_val (RESET_VALUE[i]),
      .q       (io_Q[i])
    );
  end

endmodule : nregister_e

// File: tb/tb_nregister_e.sv
// Self-checking bench for nregister_e: table-driven vectors plus scoreboard.
module tb_nregister_e;

  localparam int HalfPeriod = 120;

  logic       clk;
  logic       reset;
  logic [7:0] io_D;
  logic       io_enable;
  logic [7:0] io_Q;

  logic       reset1;
  logic [0:0] io_D1;
  logic       io_enable1;
  logic [0:0] io_Q1;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];

  nregister_e u_dut (
    .clk       (clk),
    .reset     (reset),
    .io_D      (io_D),
    .io_enable (io_enable),
    .io_Q      (io_Q)
  );

  nregister_e #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_dut1 (
    .clk       (clk),
    .reset     (reset1),
    .io_D      (io_D1),
    .io_enable (io_enable1),
    .io_Q      (io_Q1)
  );

  initial clk = 1'b0;
  always #HalfPeriod clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rst, input logic en,
                              input logic [7:0] d, input logic [7:0] exp);
    vec_t v;
    v.name = name;
    v.rst  = rst;
    v.en   = en;
    v.d    = d;
    v.exp  = exp;
    return v;
  endfunction

  initial begin
    logic [7:0] prev;
    logic [7:0] exp_q;
    bit         have_prev;
    checks    = 0;
    errors    = 0;
    have_prev = 0;
    prev      = 8'h00;
    reset     = 1'b0;
    io_D      = 8'h00;
    io_enable = 1'b0;
    reset1    = 1'b0;
    io_D1     = 1'b0;
    io_enable1 = 1'b0;

    vecs.push_back(mk("reset",        1'b1, 1'b1, 8'hA5, 8'h00));
    vecs.push_back(mk("load_3c",      1'b0, 1'b1, 8'h3C, 8'h3C));
    vecs.push_back(mk("hold_ff",      1'b0, 1'b0, 8'hFF, 8'h3C));
    vecs.push_back(mk("hold_00",      1'b0, 1'b0, 8'h00, 8'h3C));
    vecs.push_back(mk("hold_81",      1'b0, 1'b0, 8'h81, 8'h3C));
    vecs.push_back(mk("stream_01",    1'b0, 1'b1, 8'h01, 8'h01));
    vecs.push_back(mk("stream_02",    1'b0, 1'b1, 8'h02, 8'h02));
    vecs.push_back(mk("stream_04",    1'b0, 1'b1, 8'h04, 8'h04));
    vecs.push_back(mk("stream_80",    1'b0, 1'b1, 8'h80, 8'h80));
    vecs.push_back(mk("load_55",      1'b0, 1'b1, 8'h55, 8'h55));
    vecs.push_back(mk("rst_over_en",  1'b1, 1'b1, 8'hAA, 8'h00));
    vecs.push_back(mk("resume_7e",    1'b0, 1'b1, 8'h7E, 8'h7E));
    vecs.push_back(mk("hold_after",   1'b0, 1'b0, 8'hC3, 8'h7E));

    // Table: drive on negedge, check pre-edge hold, compare after the edge.
    foreach (vecs[i]) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      io_enable = vecs[i].en;
      io_D      = vecs[i].d;
      sb.push_back(vecs[i].exp);
      #1;
      if (have_prev) check({vecs[i].name, "_pre_edge"}, 64'(io_Q), 64'(prev));
      @(posedge clk);
      #1;
      exp_q = sb.pop_front();
      check(vecs[i].name, 64'(io_Q), 64'(exp_q));
      prev      = exp_q;
      have_prev = 1;
    end

    // io_D wiggles between edges with enable low, then reset asserted mid-cycle.
    @(negedge clk);
    io_enable = 1'b0;
    io_D      = 8'hAA;
    #10;
    io_D      = 8'h11;
    #10;
    check("mid_d_change", 64'(io_Q), 64'h7E);
    reset = 1'b1;
    #20;
    check("mid_reset_no_effect", 64'(io_Q), 64'h7E);
    sb.push_back(8'h00);
    @(posedge clk);
    #1;
    check("mid_reset_edge", 64'(io_Q), 64'(sb.pop_front()));
    // Release with enable high: must load on the very next edge.
    @(negedge clk);
    reset     = 1'b0;
    io_enable = 1'b1;
    io_D      = 8'hC3;
    sb.push_back(8'hC3);
    @(posedge clk);
    #1;
    check("no_dead_cycle", 64'(io_Q), 64'(sb.pop_front()));
    io_D = 8'h0F;
    #5;
    check("no_comb_path", 64'(io_Q), 64'hC3);

    // WIDTH=1, RESET_VALUE=1 instance.
    @(negedge clk);
    reset1     = 1'b1;
    io_enable1 = 1'b0;
    io_D1      = 1'b0;
    @(posedge clk);
    #1;
    check("w1_reset", 64'(io_Q1), 64'h1);
    @(negedge clk);
    reset1     = 1'b0;
    io_enable1 = 1'b1;
    io_D1      = 1'b0;
    @(posedge clk);
    #1;
    check("w1_load0", 64'(io_Q1), 64'h0);
    @(negedge clk);
    io_enable1 = 1'b0;
    io_D1      = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("w1_hold", 64'(io_Q1), 64'h0);
    end

    if (sb.size() != 0) check("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_nregister_e
